burst_mem_responder: RTL and testbench

Memory-side responder for the 4-beat, 64-bit burst protocol driven by the cache-line adaptor. It accepts a line-aligned read or write request, waits a programmable access latency, and then streams or absorbs four 64-bit beats while asserting `resp_o`. Its backing store is a small register-array line memory. It sits in place of main memory below the LLC adaptor, for simulation and on-chip scratch use.

---
 rtl/burst_mem_pkg.sv | 17 +
 rtl/burst_line_ram.sv | 35 +++
 rtl/burst_mem_responder.sv | 136 +++++++++++++
 tb/tb_burst_mem_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_mem_pkg.sv
// rtl/burst_mem_pkg.sv - shared constants and state type for the burst memory responder
package burst_mem_pkg;

  localparam int BEATS       = 4;
  localparam int BEAT_W      = 64;
  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD_BURST,
    ST_WR_BURST,
    ST_DONE
  } burst_state_t;

endpackage

// File: rtl/burst_line_ram.sv
// rtl/burst_line_ram.sv - register-array line store with beat-granular write and read ports
import burst_mem_pkg::*;

module burst_line_ram #(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [1:0]          wr_beat,
  input  logic [BEAT_W-1:0]   wr_data,
  input  logic [IDX_BITS-1:0] rd_idx,
  input  logic [1:0]          rd_beat,
  output logic [BEAT_W-1:0]   rd_data
);

  localparam int LINES = 1 << IDX_BITS;

  logic [LINE_W-1:0] mem [LINES];

  // Whole store clears on reset so a reset mid-write leaves no partial line behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx][{wr_beat, 6'd0} +: BEAT_W] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx][{rd_beat, 6'd0} +: BEAT_W];

endmodule

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - latency-programmable 4-beat burst memory responder
import burst_mem_pkg::*;

module burst_mem_responder #(
  parameter int LATENCY  = 3,
  parameter int IDX_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic              resp_o,
  output logic [15:0]       txn_count_o
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  burst_state_t        state;
  burst_state_t        next_state;
  logic [3:0]          lat_cnt;
  logic [1:0]          beat_cnt;
  logic [IDX_BITS-1:0] idx_q;
  logic                op_rd;
  logic [15:0]         txn_cnt;
  logic                ram_we;
  logic [BEAT_W-1:0]   rd_beat_data;
  logic                unused_addr;

  // Offset bits and bits above the index are don't-care: lines alias modulo the store size.
  assign unused_addr = ^{address_i[31:OFFSET_BITS+IDX_BITS], address_i[OFFSET_BITS-1:0]};

  burst_line_ram #(
    .IDX_BITS (IDX_BITS)
  ) u_line_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_we),
    .wr_idx  (idx_q),
    .wr_beat (beat_cnt),
    .wr_data (burst_i),
    .rd_idx  (idx_q),
    .rd_beat (beat_cnt),
    .rd_data (rd_beat_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and outputs; outputs depend on registered state and counters only.
  always_comb begin
    next_state = state;
    resp_o     = 1'b0;
    burst_o    = '0;
    ram_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (read_i || write_i) begin
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == 4'd0) begin
          next_state = op_rd ? ST_RD_BURST : ST_WR_BURST;
        end
      end
      ST_RD_BURST: begin
        resp_o  = 1'b1;
        burst_o = rd_beat_data;
        if (beat_cnt == 2'd3) begin
          next_state = ST_DONE;
        end
      end
      ST_WR_BURST: begin
        resp_o = 1'b1;
        ram_we = 1'b1;
        if (beat_cnt == 2'd3) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Request capture, latency/beat counting and completed-transaction count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt  <= '0;
      beat_cnt <= '0;
      idx_q    <= '0;
      op_rd    <= 1'b0;
      txn_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (read_i || write_i) begin
            idx_q   <= address_i[OFFSET_BITS +: IDX_BITS];
            op_rd   <= read_i;
            lat_cnt <= LAT_LOAD;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 4'd0) begin
            beat_cnt <= 2'd0;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_RD_BURST, ST_WR_BURST: begin
          beat_cnt <= beat_cnt + 2'd1;
        end
        ST_DONE: begin
          txn_cnt <= txn_cnt + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign txn_count_o = txn_cnt;

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - self-checking bench for burst_mem_responder
module tb_burst_mem_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;
  logic [15:0] txn_count_o;

  logic [31:0] address1;
  logic        read1;
  logic        write1;
  logic [63:0] burst_in1;
  logic [63:0] burst_out1;
  logic        resp1;
  logic [15:0] txn_count1;

  int total = 0;
  int bad   = 0;

  logic [255:0] model_mem [16];
  int           model_txn;

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp_line;
    bit           wiggle;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  burst_mem_responder #(.LATENCY(LAT), .IDX_BITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .address_i   (address_i),
    .read_i      (read_i),
    .write_i     (write_i),
    .burst_i     (burst_i),
    .burst_o     (burst_o),
    .resp_o      (resp_o),
    .txn_count_o (txn_count_o)
  );

  burst_mem_responder #(.LATENCY(1), .IDX_BITS(4)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .address_i   (address1),
    .read_i      (read1),
    .write_i     (write1),
    .burst_i     (burst_in1),
    .burst_o     (burst_out1),
    .resp_o      (resp1),
    .txn_count_o (txn_count1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction on the main instance, started and ended at a negedge.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wdata, input logic [255:0] exp_line,
                         input bit wiggle, input string tag);
    int idx;
    idx = int'(addr[8:5]);
    address_i = addr;
    read_i    = rd;
    write_i   = wr;
    burst_i   = wdata[63:0];
    @(posedge clk);
    for (int c = 1; c <= LAT + 5; c++) begin
      bit hi;
      int k;
      @(negedge clk);
      hi = (c >= LAT + 1) && (c <= LAT + 4);
      k  = c - LAT - 1;
      check({tag, " resp"}, {63'd0, resp_o}, {63'd0, hi});
      if (hi && rd) begin
        check({tag, " rdata"}, burst_o, exp_line[64*k +: 64]);
      end else begin
        check({tag, " burst_o idle"}, burst_o, 64'd0);
      end
      if (hi && !rd) begin
        burst_i = wdata[64*k +: 64];
      end
      if (wiggle && c == 1) begin
        address_i = addr ^ 32'h0000_00E0;
        read_i    = !rd;
        write_i   = !wr;
      end
    end
    read_i  = 1'b0;
    write_i = 1'b0;
    if (!rd && wr) begin
      model_mem[idx] = wdata;
    end
    model_txn++;
    @(negedge clk);
    check({tag, " txn_count"}, {48'd0, txn_count_o}, 64'(model_txn & 16'hFFFF));
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) begin
      v[32*i +: 32] = $urandom;
    end
    return v;
  endfunction

  initial begin
    logic [255:0] l60;
    logic [255:0] d2;
    logic [255:0] d3;
    logic [255:0] wl;

    l60 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    d2  = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
           64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};
    d3  = {64'hA5A5_0000_FFFF_0003, 64'h0123_4567_89AB_CDEF,
           64'hFEDC_BA98_7654_3210, 64'h5A5A_1111_2222_3333};

    //        rd    wr    addr          wdata   exp_line wiggle
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0040, '0,     '0,      1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0060, l60,    '0,      1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0060, '0,     l60,     1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_007F, '0,     l60,     1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'h0000_0060, '1,     l60,     1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0060, '0,     l60,     1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0020, d2,     '0,      1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0220, '0,     d2,      1'b1};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_0040, d3,     '0,      1'b1};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_0040, '0,     d3,      1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_00A0, '0,     '0,      1'b0};

    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    model_txn = 0;

    reset     = 1'b1;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    address1  = '0;
    read1     = 1'b0;
    write1    = 1'b0;
    burst_in1 = '0;
    repeat (2) @(negedge clk);
    check("reset resp", {63'd0, resp_o}, 64'd0);
    check("reset burst_o", burst_o, 64'd0);
    check("reset txn_count", {48'd0, txn_count_o}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven directed vectors.
    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_line,
              tbl[i].wiggle, $sformatf("vec%0d", i));
    end

    // Minimum latency: first beat on the second cycle after acceptance.
    read1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("lat1 resp c%0d", c), {63'd0, resp1}, {63'd0, (c >= 2 && c <= 5)});
    end
    read1 = 1'b0;
    @(negedge clk);
    check("lat1 txn_count", {48'd0, txn_count1}, 64'd1);

    // Held read: re-acceptance only at the edge after DONE, giving a LAT+6 cycle period.
    address_i = 32'h0000_0060;
    read_i    = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 2 * (LAT + 6); c++) begin
      int ph;
      @(negedge clk);
      ph = (c - 1) % (LAT + 6) + 1;
      check($sformatf("hold resp c%0d", c), {63'd0, resp_o},
            {63'd0, (ph >= LAT + 1 && ph <= LAT + 4)});
    end
    read_i = 1'b0;
    model_txn += 2;
    @(negedge clk);
    check("hold txn_count", {48'd0, txn_count_o}, 64'(model_txn & 16'hFFFF));

    // Randomized transactions against the line-array model.
    for (int n = 0; n < 24; n++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 2));
      a  = $urandom;
      wl = rand_line();
      run_txn(op != 1, op != 0, a, wl, model_mem[int'(a[8:5])], 1'b0, $sformatf("rnd%0d", n));
    end

    // Reset during write beat 2: partial line is lost along with everything else.
    address_i = 32'h0000_0080;
    write_i   = 1'b1;
    wl        = rand_line();
    burst_i   = wl[63:0];
    @(posedge clk);
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      if (c >= LAT + 1) burst_i = wl[64*(c-LAT-1) +: 64];
    end
    reset = 1'b1;
    #1;
    check("midrst resp", {63'd0, resp_o}, 64'd0);
    check("midrst burst_o", burst_o, 64'd0);
    check("midrst txn_count", {48'd0, txn_count_o}, 64'd0);
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    model_txn = 0;
    @(negedge clk);
    reset   = 1'b0;
    write_i = 1'b0;
    @(negedge clk);
    run_txn(1'b1, 1'b0, 32'h0000_0080, '0, '0, 1'b0, "postrst line4");
    run_txn(1'b1, 1'b0, 32'h0000_0060, '0, '0, 1'b0, "postrst line3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
